// File: rtl/ch_unit_pkg.sv
// Shared types and constants for the record stream packer.
// The FSM enum always lists HDR so the encoding is the same with or without headers.
package ch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } packer_state_t;

  localparam logic [15:0] HEADER_MAGIC = 16'hCA5E;
  localparam logic [31:0] PAD_WORD     = 32'h0000_0000;

endpackage

// File: rtl/record_stream_packer_if.sv
// AXI4-Stream style output bus of the record stream packer.
interface record_stream_packer_if;

  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);

endinterface

// File: rtl/record_fifo.sv
// First-word fall-through FIFO; pointers and count reset asynchronously,
// the storage array is not reset.
module record_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign doPop   = pop && !empty;
  // A push into a full FIFO is legal when a pop frees the slot in the same cycle.
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/record_stream_packer.sv
// Captures record-unit words on dataValid rising edges and emits them as framed
// stream beats. Define RECORD_PACKER_HEADER_EN to prefix each frame with a header word.
module record_stream_packer
  import ch_unit_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned FRAME_WORDS = 256
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          enable,
  input  logic [31:0]                   recordedData,
  input  logic                          dataValid,
  record_stream_packer_if.master        m,
  output logic [15:0]                   overflowCount,
  output logic [15:0]                   frameSeq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(FRAME_WORDS);

  packer_state_t  state;
  packer_state_t  nextState;
  logic           dvPrev;
  logic [CW-1:0]  wrWordCnt;
  logic           capture;
  logic           lastWord;
  logic           space;
  logic           push;
  logic [32:0]    pushData;
  logic           dataPush;
  logic           padPush;
  logic           overflowEv;
  logic           pop;
  logic [32:0]    popWord;
  logic           fifoFull;
  logic           fifoEmpty;
  logic [AW:0]    fifoCount;

  assign capture  = dataValid && !dvPrev && enable;
  assign lastWord = (wrWordCnt == CW'(FRAME_WORDS - 1));
  assign pop      = !fifoEmpty && m.m_tready;
  assign space    = !fifoFull || pop;

  assign m.m_tvalid = !fifoEmpty;
  assign m.m_tdata  = fifoEmpty ? '0 : popWord[31:0];
  assign m.m_tlast  = fifoEmpty ? 1'b0 : popWord[32];

  record_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk      (clk),
    .resetN   (resetN),
    .push     (push),
    .pushData (pushData),
    .pop      (pop),
    .popData  (popWord),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  always_comb begin
    assert (fifoFull == (fifoCount == (AW+1)'(DEPTH)));
  end

  always_comb begin
    nextState  = state;
    push       = 1'b0;
    pushData   = '0;
    dataPush   = 1'b0;
    padPush    = 1'b0;
    overflowEv = 1'b0;
    case (state)
      IDLE: begin
`ifdef RECORD_PACKER_HEADER_EN
        if (enable) nextState = HDR;
`else
        if (enable) nextState = RUN;
`endif
      end
`ifdef RECORD_PACKER_HEADER_EN
      HDR: begin
        if (capture) overflowEv = 1'b1;
        if (!enable) begin
          nextState = IDLE;
        end else if (space) begin
          push      = 1'b1;
          pushData  = {1'b0, HEADER_MAGIC, frameSeq};
          nextState = RUN;
        end
      end
`endif
      RUN: begin
        if (!enable) begin
          nextState = (wrWordCnt == '0) ? IDLE : FLUSH;
        end else if (capture) begin
          if (space) begin
            push     = 1'b1;
            dataPush = 1'b1;
            pushData = {lastWord, recordedData};
`ifdef RECORD_PACKER_HEADER_EN
            if (lastWord) nextState = HDR;
`endif
          end else begin
            overflowEv = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (space) begin
          push      = 1'b1;
          padPush   = 1'b1;
          pushData  = {1'b1, PAD_WORD};
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      dvPrev        <= 1'b0;
      wrWordCnt     <= '0;
      frameSeq      <= '0;
      overflowCount <= '0;
    end else begin
      state  <= nextState;
      dvPrev <= dataValid;
      if (dataPush) begin
        wrWordCnt <= lastWord ? '0 : wrWordCnt + 1'b1;
      end else if (padPush) begin
        wrWordCnt <= '0;
      end
      if ((dataPush && lastWord) || padPush) frameSeq <= frameSeq + 1'b1;
      if (overflowEv && (overflowCount != '1)) overflowCount <= overflowCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_record_stream_packer.sv
// Self-checking bench for record_stream_packer (header feature off, DEPTH=8, FRAME_WORDS=4).
module tb_record_stream_packer;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] recordedData = '0;
  logic        dataValid = 1'b0;
  logic [15:0] overflowCount;
  logic [15:0] frameSeq;

  record_stream_packer_if sif ();

  record_stream_packer #(
    .DEPTH       (8),
    .FRAME_WORDS (4)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .enable        (enable),
    .recordedData  (recordedData),
    .dataValid     (dataValid),
    .m             (sif),
    .overflowCount (overflowCount),
    .frameSeq      (frameSeq)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [32:0] sb [$];

  initial sif.m_tready = 1'b0;

  // One cycle: set inputs at the falling edge, then score the beat the next rising edge takes.
  task automatic drive_cycle(input logic e, input logic d, input logic [31:0] w, input logic r);
    logic [32:0] exp;
    @(negedge clk);
    enable = e;
    dataValid = d;
    recordedData = w;
    sif.m_tready = r;
    if (sif.m_tvalid && sif.m_tready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat: unexpected beat tlast=%0b tdata=%h, none expected", sif.m_tlast, sif.m_tdata);
      end else begin
        exp = sb.pop_front();
        if ({sif.m_tlast, sif.m_tdata} !== exp)
          begin
            errors++;
            $display("FAIL beat: got tlast=%0b tdata=%h, expected tlast=%0b tdata=%h",
                     sif.m_tlast, sif.m_tdata, exp[32], exp[31:0]);
          end
      end
    end
  endtask

  task automatic capture_word(input logic [31:0] w, input logic r);
    drive_cycle(1'b1, 1'b1, w, r);
    drive_cycle(1'b1, 1'b0, w, r);
  endtask

  task automatic drain(input logic e, input int unsigned bound);
    int unsigned n = 0;
    while (sb.size() != 0 && n < bound) begin
      drive_cycle(e, 1'b0, 32'h0, 1'b1);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sif.m_tvalid, sif.m_tlast, sif.m_tdata, overflowCount, frameSeq} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: tvalid=%0b tlast=%0b tdata=%h ovf=%0d seq=%0d, expected all 0",
               sif.m_tvalid, sif.m_tlast, sif.m_tdata, overflowCount, frameSeq);
    end
    resetN = 1'b1;
  endtask

  task automatic test_basic_capture;
    logic [31:0] w;
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      w = 32'h1111_1111 * i;
      sb.push_back({(i == 4), w});
      drive_cycle(1'b1, 1'b1, w, 1'b1);
      if (i == 1) begin
        @(posedge clk);
        #1;
        checks++;
        if (sif.m_tvalid !== 1'b1 || sif.m_tdata !== w) begin
          errors++;
          $display("FAIL fwft_latency: tvalid=%0b tdata=%h, expected 1 %h", sif.m_tvalid, sif.m_tdata, w);
        end
      end
      drive_cycle(1'b1, 1'b0, w, 1'b1);
    end
    drain(1'b1, 20);
    checks++;
    if (frameSeq !== 16'd1) begin
      errors++;
      $display("FAIL basic_frameSeq: got %0d, expected 1", frameSeq);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) sb.push_back({(i == 3 || i == 7), 32'hA000_0000 + i});
      capture_word(32'hA000_0000 + i, 1'b0);
    end
    checks++;
    if (overflowCount !== 16'd2) begin
      errors++;
      $display("FAIL overflow_count: got %0d, expected 2", overflowCount);
    end
    checks++;
    if (sif.m_tvalid !== 1'b1 || sif.m_tdata !== 32'hA000_0000 || frameSeq !== 16'd3) begin
      errors++;
      $display("FAIL overflow_hold: tvalid=%0b tdata=%h seq=%0d, expected 1 a0000000 3",
               sif.m_tvalid, sif.m_tdata, frameSeq);
    end
    // Full FIFO: a capture coinciding with a pop must be accepted.
    sb.push_back({1'b0, 32'hB000_0000});
    capture_word(32'hB000_0000, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      sb.push_back({(i == 3), 32'hB000_0000 + i});
      capture_word(32'hB000_0000 + i, 1'b1);
    end
    drain(1'b1, 40);
    checks++;
    if (overflowCount !== 16'd2 || frameSeq !== 16'd4) begin
      errors++;
      $display("FAIL full_push_pop: ovf=%0d seq=%0d, expected 2 4", overflowCount, frameSeq);
    end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      sb.push_back({1'b0, 32'hF000_0000 + i});
      capture_word(32'hF000_0000 + i, 1'b1);
    end
    sb.push_back({1'b1, 32'h0000_0000});
    // The rising dataValid coincides with enable falling, so it must be dropped.
    drive_cycle(1'b0, 1'b1, 32'hDEAD_DEAD, 1'b1);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    drain(1'b0, 20);
    checks++;
    if (frameSeq !== 16'd5 || overflowCount !== 16'd2) begin
      errors++;
      $display("FAIL flush_counters: seq=%0d ovf=%0d, expected 5 2", frameSeq, overflowCount);
    end
    drive_cycle(1'b0, 1'b1, 32'hBEEF_BEEF, 1'b1);
    repeat (4) drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (sif.m_tvalid !== 1'b0 || overflowCount !== 16'd2) begin
      errors++;
      $display("FAIL idle_ignore: tvalid=%0b ovf=%0d, expected 0 2", sif.m_tvalid, overflowCount);
    end
  endtask

  task automatic test_level_dv;
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    sb.push_back({1'b0, 32'h5555_5555});
    repeat (5) drive_cycle(1'b1, 1'b1, 32'h5555_5555, 1'b1);
    drain(1'b1, 10);
    repeat (3) drive_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (sif.m_tvalid !== 1'b0 || sif.m_tdata !== 32'h0) begin
      errors++;
      $display("FAIL level_single: tvalid=%0b tdata=%h, expected 0 00000000", sif.m_tvalid, sif.m_tdata);
    end
  endtask

  task automatic test_back_to_back;
    logic        held = 1'b0;
    logic [32:0] heldWord = '0;
    logic        r = 1'b0;
    int unsigned n = 0;
    for (int i = 1; i <= 3; i++) begin
      sb.push_back({(i == 3), 32'hC000_0000 + i});
      capture_word(32'hC000_0000 + i, 1'b0);
    end
    while (sb.size() != 0 && n < 40) begin
      r = ~r;
      drive_cycle(1'b1, 1'b0, 32'h0, r);
      if (held) begin
        checks++;
        if ({sif.m_tlast, sif.m_tdata} !== heldWord) begin
          errors++;
          $display("FAIL stall_stable: got tlast=%0b tdata=%h, expected tlast=%0b tdata=%h",
                   sif.m_tlast, sif.m_tdata, heldWord[32], heldWord[31:0]);
        end
      end
      held = sif.m_tvalid && !sif.m_tready;
      heldWord = {sif.m_tlast, sif.m_tdata};
      n++;
    end
    checks++;
    if (sb.size() != 0 || frameSeq !== 16'd6) begin
      errors++;
      $display("FAIL toggle_drain: left=%0d seq=%0d, expected 0 6", sb.size(), frameSeq);
      sb.delete();
    end
  endtask

  task automatic test_reset_midframe;
    capture_word(32'hD000_0000, 1'b0);
    capture_word(32'hD000_0001, 1'b0);
    checks++;
    if (sif.m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL prereset_valid: tvalid=%0b, expected 1", sif.m_tvalid);
    end
    @(negedge clk);
    resetN = 1'b0;
    #1;
    checks++;
    if ({sif.m_tvalid, sif.m_tlast, sif.m_tdata, overflowCount, frameSeq} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: tvalid=%0b tlast=%0b tdata=%h ovf=%0d seq=%0d, expected all 0",
               sif.m_tvalid, sif.m_tlast, sif.m_tdata, overflowCount, frameSeq);
    end
    @(negedge clk);
    resetN = 1'b1;
    repeat (5) drive_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (sif.m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL no_pad_after_reset: tvalid=%0b, expected 0", sif.m_tvalid);
    end
    sb.push_back({1'b0, 32'hE000_0000});
    capture_word(32'hE000_0000, 1'b1);
    drain(1'b1, 10);
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_overflow();
    test_flush();
    test_level_dv();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
